// File: rtl/mod_half_addsub_pkg.sv
// Shared constants for the Kyber/Dilithium modular datapath.
// Moduli, lane widths, mode encoding and small lane helpers.
package mod_half_addsub_pkg;

    localparam int unsigned DW  = 24;
    localparam int unsigned KW  = 12;
    localparam int unsigned DLW = 23;

    localparam logic [DW-1:0] KQ = 24'd3329;
    localparam logic [DW-1:0] DQ = 24'd8380417;

    localparam logic MODE_KYBER = 1'b0;
    localparam logic MODE_DIL   = 1'b1;

    function automatic logic [DW-1:0] modq(input logic mode);
        return (mode == MODE_DIL) ? DQ : KQ;
    endfunction

    function automatic logic [DW-1:0] lane_mask(
        input logic          mode,
        input logic [DW-1:0] x
    );
        logic [DW-1:0] m;
        m = '0;
        if (mode == MODE_DIL)
            m[DLW-1:0] = x[DLW-1:0];
        else
            m[KW-1:0] = x[KW-1:0];
        return m;
    endfunction

endpackage

// File: rtl/mod_half_addsub_half.sv
// Combinational halve-mod-q for one lane: x/2 mod q.
// Odd inputs get q added first so the shift stays exact.
module mod_half
    import mod_half_addsub_pkg::*;
(
    input  logic [DW-1:0] x_i,
    input  logic          mode_i,
    output logic [DW-1:0] y_o
);

    logic [DW:0] sum;

    // One spare bit keeps x+q from wrapping for the 23-bit modulus
    always_comb begin
        sum = {1'b0, x_i};
        if (x_i[0])
            sum = sum + {1'b0, modq(mode_i)};
    end

    assign y_o = sum[DW:1];

endmodule

// File: rtl/mod_half_addsub.sv
// Inverse butterfly post-stage: (u,v) -> ((u+v)/2, (u-v)/2) mod q.
// Two registered stages with valid/ready; mode rides with each beat.
module mod_half_addsub
    import mod_half_addsub_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          mode,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_u,
    input  logic [DW-1:0] in_v,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_a,
    output logic [DW-1:0] out_b
);

    logic          s1_valid_q;
    logic          s1_mode_q;
    logic [DW-1:0] s1_s_q;
    logic [DW-1:0] s1_d_q;

    logic          out_valid_q;
    logic [DW-1:0] out_a_q;
    logic [DW-1:0] out_b_q;

    logic          stage2_free;
    logic          s1_adv;
    logic          in_fire;

    logic [DW-1:0] u_m;
    logic [DW-1:0] v_m;
    logic [DW-1:0] q_in;
    logic [DW:0]   sum_w;
    logic [DW:0]   dif_w;
    logic [DW-1:0] s_d;
    logic [DW-1:0] d_d;

    logic [DW-1:0] a_d;
    logic [DW-1:0] b_d;

    assign stage2_free = !out_valid_q || out_ready;
    assign s1_adv      = s1_valid_q && stage2_free;
    assign in_ready    = !s1_valid_q || s1_adv;
    assign in_fire     = in_valid && in_ready;

    // Stage 1 math: modular sum and difference of the masked operands
    always_comb begin
        u_m   = lane_mask(mode, in_u);
        v_m   = lane_mask(mode, in_v);
        q_in  = modq(mode);
        sum_w = {1'b0, u_m} + {1'b0, v_m};
        s_d   = sum_w[DW-1:0];
        if (sum_w >= {1'b0, q_in})
            s_d = sum_w[DW-1:0] - q_in;
        dif_w = {1'b0, u_m} - {1'b0, v_m};
        d_d   = dif_w[DW-1:0];
        if (dif_w[DW])
            d_d = dif_w[DW-1:0] + q_in;
    end

    mod_half u_half_a (
        .x_i    (s1_s_q),
        .mode_i (s1_mode_q),
        .y_o    (a_d)
    );

    mod_half u_half_b (
        .x_i    (s1_d_q),
        .mode_i (s1_mode_q),
        .y_o    (b_d)
    );

    // Stage 1 register: loads on accept, empties when it advances
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_mode_q  <= MODE_KYBER;
            s1_s_q     <= '0;
            s1_d_q     <= '0;
        end else begin
            if (in_fire) begin
                s1_valid_q <= 1'b1;
                s1_mode_q  <= mode;
                s1_s_q     <= s_d;
                s1_d_q     <= d_d;
            end else if (s1_adv) begin
                s1_valid_q <= 1'b0;
            end
        end
    end

    // Output register: holds while stalled, refills on advance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_a_q     <= '0;
            out_b_q     <= '0;
        end else begin
            if (s1_adv) begin
                out_valid_q <= 1'b1;
                out_a_q     <= a_d;
                out_b_q     <= b_d;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_a     = out_a_q;
    assign out_b     = out_b_q;

endmodule

// File: tb/tb_mod_half_addsub.sv
// Directed bench for mod_half_addsub.
// Drives #1 after posedge, samples on negedge.
module tb_mod_half_addsub;

    logic        clk = 1'b0;
    logic        rst;
    logic        mode;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] in_u;
    logic [23:0] in_v;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] out_a;
    logic [23:0] out_b;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit sb_on   = 1'b0;

    logic [47:0] exp_q[$];
    logic [47:0] got_q[$];
    int          got_cyc[$];

    mod_half_addsub dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_u      (in_u),
        .in_v      (in_v),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_a     (out_a),
        .out_b     (out_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk)
        if (sb_on && out_valid && out_ready) begin
            got_q.push_back({out_a, out_b});
            got_cyc.push_back(cyc);
        end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [47:0] model(input logic m,
                                          input logic [23:0] u,
                                          input logic [23:0] v);
        longint q, inv2, s, d, a, b;
        q    = m ? 64'd8380417 : 64'd3329;
        inv2 = (q + 1) / 2;
        s    = (longint'(u) + longint'(v)) % q;
        d    = (longint'(u) - longint'(v) + q) % q;
        a    = (s * inv2) % q;
        b    = (d * inv2) % q;
        return {a[23:0], b[23:0]};
    endfunction

    task automatic send(input logic m, input logic [23:0] u,
                        input logic [23:0] v);
        int n;
        in_valid = 1'b1;
        mode     = m;
        in_u     = u;
        in_v     = v;
        n        = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 100) begin
                check("send_timeout", in_ready, 1);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic sendx(input logic m, input logic [23:0] u,
                         input logic [23:0] v);
        exp_q.push_back(model(m, u, v));
        send(m, u, v);
    endtask

    task automatic one(input string tag, input logic m,
                       input logic [23:0] u, input logic [23:0] v,
                       input logic [23:0] ea, input logic [23:0] eb);
        send(m, u, v);
        in_valid = 1'b0;
        @(negedge clk);
        check({tag, "_v1"}, out_valid, 0);
        @(negedge clk);
        check({tag, "_v2"}, out_valid, 1);
        check({tag, "_a"}, out_a, ea);
        check({tag, "_b"}, out_b, eb);
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (got_q.size() < exp_q.size() && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        check({tag, "_cnt"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            if (i < got_q.size())
                check(tag, got_q[i], exp_q[i]);
    endtask

    task automatic sb_clear();
        exp_q.delete();
        got_q.delete();
        got_cyc.delete();
    endtask

    initial begin
        rst       = 1'b1;
        mode      = 1'b0;
        in_valid  = 1'b0;
        in_u      = '0;
        in_v      = '0;
        out_ready = 1'b1;
        #3;
        check("rst_ov", out_valid, 0);
        check("rst_a", out_a, 0);
        check("rst_b", out_b, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_ir", in_ready, 1);
        @(posedge clk);
        #1;

        one("k5_3", 1'b0, 24'd5, 24'd3, 24'd4, 24'd1);
        one("k0_1", 1'b0, 24'd0, 24'd1, 24'd1665, 24'd1664);
        one("d1_m1", 1'b1, 24'd1, 24'd8380416, 24'd0, 24'd1);
        one("dm1_0", 1'b1, 24'd8380416, 24'd0,
            24'd4190208, 24'd4190208);

        sb_clear();
        sb_on = 1'b1;
        sendx(1'b0, 24'd3000, 24'd2999);
        sendx(1'b1, 24'd8000000, 24'd7999999);
        sendx(1'b0, 24'd1, 24'd3328);
        sendx(1'b1, 24'd12345, 24'd8380000);
        sendx(1'b0, 24'd3328, 24'd3328);
        sendx(1'b1, 24'd7, 24'd0);
        in_valid = 1'b0;
        drain("alt");
        if (got_cyc.size() == 6)
            check("alt_rate", got_cyc[5] - got_cyc[0], 5);
        else
            check("alt_rate_n", got_cyc.size(), 6);
        @(posedge clk);
        #1;

        sb_clear();
        out_ready = 1'b0;
        sendx(1'b0, 24'd10, 24'd4);
        sendx(1'b1, 24'd100, 24'd50);
        in_valid = 1'b1;
        mode     = 1'b0;
        in_u     = 24'd3;
        in_v     = 24'd0;
        repeat (3) begin
            @(negedge clk);
            check("stall_ir", in_ready, 0);
            check("stall_ov", out_valid, 1);
            check("stall_a", out_a, 7);
            check("stall_b", out_b, 3);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        sendx(1'b0, 24'd3, 24'd0);
        sendx(1'b1, 24'd0, 24'd2);
        in_valid = 1'b0;
        drain("stall");
        if (exp_q.size() == 4) begin
            check("stall_e2", exp_q[2], {24'd1666, 24'd1666});
            check("stall_e3", exp_q[3], {24'd1, 24'd8380416});
        end
        @(posedge clk);
        #1;

        sb_clear();
        sb_on = 1'b0;
        send(1'b0, 24'd5, 24'd3);
        send(1'b0, 24'd0, 24'd1);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("arst_ov", out_valid, 0);
        check("arst_a", out_a, 0);
        check("arst_b", out_b, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        sb_clear();
        sb_on = 1'b1;
        @(negedge clk);
        check("arst_ir", in_ready, 1);
        repeat (5) @(negedge clk);
        check("arst_stale", got_q.size(), 0);
        check("arst_ov2", out_valid, 0);
        @(posedge clk);
        #1;

        sb_clear();
        for (int i = 0; i < 24; i++) begin
            logic        m;
            int unsigned q, a, b, u, v;
            m = 1'($urandom_range(1));
            q = m ? 8380417 : 3329;
            a = $urandom_range(q - 1);
            b = $urandom_range(q - 1);
            u = (a + b) % q;
            v = (a + q - b) % q;
            exp_q.push_back({a[23:0], b[23:0]});
            send(m, u[23:0], v[23:0]);
        end
        in_valid = 1'b0;
        drain("rand");
        sb_on = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/mod_half_addsub.md
Name: mod_half_addsub

Overview:
- Inverse butterfly post-stage.
- Takes a pair (u, v) produced by the modular add/sub unit, where u = a+b mod q and v = a-b mod q.
- Recovers a = (u+v)/2 mod q and b = (u-v)/2 mod q.
- Sits after the adder in the INTT datapath and removes the factor of 2 per GS layer.
- Supports Kyber (q=3329, 12-bit) and Dilithium (q=8380417, 23-bit value in 24-bit word).
- 2-stage pipeline with valid/ready handshake.

Parameters:
- KQ, 3329, Kyber modulus.
- DQ, 8380417, Dilithium modulus.
- DW, 24, data word width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- mode  in  1  0 = Kyber (operands in bits [11:0], upper bits ignored), 1 = Dilithium (bits [22:0]); sampled with in_valid
- in_valid  in  1  input beat valid
- in_ready  out  1  unit can accept a beat this cycle
- in_u  in  DW  u operand, must be < q
- in_v  in  DW  v operand, must be < q
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_a  out  DW  (u+v)/2 mod q, zero-extended
- out_b  out  DW  (u-v)/2 mod q, zero-extended

Behaviour:
- Reset: all stage valids, out_valid, out_a and out_b clear to 0 asynchronously. in_ready=1 once rst deasserts.
- Transfer rule: an input beat transfers when in_valid && in_ready. An output beat transfers when out_valid && out_ready.
- Stage 1 (registered on input transfer), with q = mode ? DQ : KQ:
  - s = u+v; if s >= q then s -= q.
  - d = u-v; if borrow then d += q.
  - Register s, d and mode.
- Stage 2 (registered when stage 1 advances): apply half(x) to s and d.
  - half(x) = x>>1 if x[0]=0, else (x+q)>>1.
  - Compute with one extra bit so that x+q never overflows (25 bits for Dilithium).
  - Results are registered to out_a/out_b; out_valid is set.
- Latency: 2 cycles from input transfer to out_valid when unstalled. Throughput: 1 beat per cycle.
- Stall:
  - stage2_free = !out_valid || out_ready.
  - s1 advances when s1_valid && stage2_free.
  - in_ready = !s1_valid || (s1 advance).
  - out_a/out_b hold stable while out_valid && !out_ready.
  - No beat is lost or duplicated.
- Mode travels with the data. Mixed-mode back-to-back beats are legal and each beat uses its own q.
- Simultaneous events:
  - Input transfer and s1 advance in the same cycle: s1 reloads, so the pipeline stays full.
  - Output consumed and new s2 result in the same cycle: out_valid stays 1 and the data updates.
- Reset mid-operation flushes all in-flight beats; no output appears after reset for pre-reset inputs.
- Out-of-range inputs (>= q) give an unspecified result value, but the handshake remains correct.
- Kyber mode: out_a[23:12] and out_b[23:12] are 0. Dilithium mode: bit 23 is 0.

Decomposition:
- Shared package (for reuse by the adder and NTT control):
  - Moduli KQ, DQ.
  - Kyber width 12, Dilithium width 23, word width 24.
  - Mode encoding constants MODE_KYBER=0, MODE_DIL=1.
- Sub-module mod_half: combinational halve-mod-q of one lane.
  - Inputs: x, mode. Output: x/2 mod q.
  - Instantiated twice in stage 2.

Test Plan:
- Kyber, u=5, v=3 -> out_a=4, out_b=1, out_valid 2 cycles after accept.
- Kyber, u=0, v=1 -> out_a=1665, out_b=1664.
  - Odd path: (1+3329)/2 = 1665.
  - Diff wrap: -1 -> 3328 -> 1664.
- Dilithium, u=1, v=8380416 -> out_a=0, out_b=1. Dilithium, u=8380416, v=0 -> out_a=out_b=4190208.
- Back-to-back alternating Kyber/Dilithium beats with out_ready=1 -> one result per cycle, in order, each reduced by its own q.
- Hold out_ready=0 for 5 cycles with 4 beats offered:
  - in_ready drops after 2 beats are buffered.
  - out_a/out_b stay stable.
  - After release, all 4 results arrive in order with no loss or duplication.
- Assert rst for 1 cycle with 2 beats in flight:
  - out_valid=0 and outputs=0 immediately (asynchronous).
  - in_ready=1 after release.
  - No stale result appears.
- Randomized: a, b < q; feed u=a+b mod q, v=a-b mod q -> outputs equal a, b.
